count_run_ctrl: RTL and testbench
=================================

Name: count_run_ctrl

Overview:
Run/pause/clear controller for the two-digit BCD seconds counter.
- Generates the count-enable tick from a prescaler, sequences the counter through a start/stop/clear FSM, and flags when a programmable BCD target is reached.
- Sits between the debounced key pulses and the seven-segment display driver.
- Replaces the free-running divided-clock scheme: everything runs on CLK, and the tick is a clock enable, not a derived clock.

Parameters:
- TICK_DIV, 50_000_000, CLK cycles per count tick (1 s at 50 MHz); legal range 2..2^26-1.
- CNT_W, 26, prescaler width; must hold TICK_DIV-1.

Ports:
- CLK  in  1  system clock.
- Rst  in  1  asynchronous, active-high reset.
- start_key  in  1  single-cycle pulse; toggles run/pause.
- clear_key  in  1  single-cycle pulse; returns to idle, zeroes count.
- lap_key  in  1  single-cycle pulse; lap freeze (see Optional Feature).
- target_bcd  in  8  terminal value, [7:4] tens, [3:0] units, BCD.
- count_bcd  out  8  live counter value, BCD.
- disp_bcd  out  8  value for the display driver.
- tick  out  1  one-cycle pulse on every count increment.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE, prescaler=0.
  - count_bcd=8'h00, disp_bcd=8'h00.
  - tick=0, running=0, done=0.
  - Lap freeze cleared.
- All outputs registered; state and outputs update on posedge CLK.
- States:
  - IDLE: count_bcd=00, prescaler=0.
  - RUN: prescaler counts.
  - PAUSE: prescaler and count frozen.
  - DONE: count frozen at target.
- Transitions (clear_key has priority over start_key in every state):
  - Any state + clear_key -> IDLE next cycle: count_bcd=00, prescaler=0, done=0, lap freeze cleared.
  - IDLE + start_key -> RUN.
  - RUN + start_key -> PAUSE. Prescaler value retained; resuming does not restart the partial second.
  - PAUSE + start_key -> RUN.
  - DONE + start_key -> IDLE; same result as clear.
- Prescaler (RUN only):
  - Increments each cycle.
  - At TICK_DIV-1: wraps to 0 and asserts tick for exactly that one cycle.
  - First tick therefore arrives TICK_DIV cycles after entering RUN from IDLE.
- Count increment (on tick):
  - Units 9 -> 0 with tens+1.
  - 99 -> 00 wrap.
  - Units-only increment otherwise.
- Target compare uses the post-increment value. When it equals target_bcd:
  - State -> DONE in the same edge that loads the new count.
  - done=1 and running=0 from the next cycle.
- start_key coinciding with the terminal tick: the tick wins. Count is updated, state -> DONE, start ignored.
- start_key coinciding with a non-terminal tick in RUN: count increments, then state -> PAUSE.
- target_bcd = 00: reached only on the 99 -> 00 wrap.
- target_bcd with a non-BCD digit (>9): never matches; counter wraps indefinitely.
- target_bcd is sampled live; changing it mid-run takes effect at the next tick.
- Count registers never hold non-BCD digits.
- Reset mid-operation: immediate return to reset values, no tick emitted.
- running = (state==RUN); done = (state==DONE).
- Without lap freeze active: disp_bcd = count_bcd.

Optional Feature:
Macro: COUNT_LAP_EN.
- Defined:
  - lap_key in RUN captures count_bcd into a lap register and sets lap freeze.
  - While frozen, disp_bcd shows the lap value; count_bcd keeps counting.
  - A second lap_key releases the freeze; disp_bcd tracks count_bcd again from the next cycle.
  - lap_key in IDLE/PAUSE/DONE is ignored.
  - Entering DONE releases the freeze.
  - clear_key and Rst release the freeze.
- Undefined: lap_key is ignored, no lap register is built, and disp_bcd = count_bcd always.

Test Plan:
1. Rst pulse mid-RUN with count=8'h37 -> all outputs 0 immediately and state=IDLE. TICK_DIV=4: start_key -> first tick 4 cycles later, count_bcd=01.
2. TICK_DIV=4, target=8'h12, run from 00 -> count passes 09 -> 10 -> 11 -> 12; done=1 and running=0 the cycle after the 12 load. Further cycles: count stays 12.
3. target=8'hA0 (invalid), run -> 98 -> 99 -> 00 wrap, done never asserts.
4. Pause 2 cycles into a prescaler period, hold 20 cycles, resume -> next tick exactly 2 cycles after resume; count unchanged during pause.
5. start_key and clear_key in the same cycle in RUN at count 45 -> IDLE, count 00, running=0. start_key on the terminal tick -> DONE, not PAUSE.
6. COUNT_LAP_EN defined: lap_key at count 23 -> disp_bcd holds 23 while count_bcd reaches 26. Second lap_key -> disp_bcd=26 next cycle. Undefined: disp_bcd tracks count_bcd throughout.

Source files
------------

// File: rtl/count_run_ctrl.sv
// ---------------------------------------------------------------------------
// count_run_ctrl
//
// Run/pause/clear controller for a two-digit BCD seconds counter. A prescaler
// running on CLK produces a one-cycle count-enable tick (a clock enable, not a
// derived clock). A start/stop/clear FSM sequences the counter, and the FSM
// parks in DONE when the post-increment count equals a programmable BCD
// target.
//
// Optional feature (macro COUNT_LAP_EN): lap freeze. When the macro is
// defined, lap_key in RUN captures the count into a lap register and the
// display shows the frozen lap value until a second lap_key, a clear, a reset
// or entry into DONE releases it. When it is undefined, lap_key is ignored
// and disp_bcd always equals count_bcd.
//
// Parameters:
//   TICK_DIV   CLK cycles per count tick, legal range 2..2^26-1
//   CNT_W      prescaler width, must hold TICK_DIV-1
//
// Ports:
//   CLK        in   system clock
//   Rst        in   asynchronous active-high reset
//   start_key  in   single-cycle pulse, toggles run/pause (DONE -> IDLE)
//   clear_key  in   single-cycle pulse, returns to IDLE with count 00
//   lap_key    in   single-cycle pulse, lap freeze toggle (COUNT_LAP_EN)
//   target_bcd in   [7:4] tens, [3:0] units terminal value, sampled live
//   count_bcd  out  live BCD counter value
//   disp_bcd   out  value for the seven-segment display driver
//   tick       out  one-cycle pulse on every count increment
//   running    out  high while in RUN
//   done       out  high while in DONE
// ---------------------------------------------------------------------------
module count_run_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       CLK,
    input  logic       Rst,
    input  logic       start_key,
    input  logic       clear_key,
    input  logic       lap_key,
    input  logic [7:0] target_bcd,
    output logic [7:0] count_bcd,
    output logic [7:0] disp_bcd,
    output logic       tick,
    output logic       running,
    output logic       done
);

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       disp_q,  disp_d;
    logic             tick_q,  tick_d;
    logic             running_q;
    logic             done_q;

    logic [7:0]       count_inc;
    logic             presc_wrap;

`ifdef COUNT_LAP_EN
    logic [7:0]       lap_q, lap_d;
    logic             lap_frz_q, lap_frz_d;
`else
    // lap_key has no function in this build.
    logic             unused_lap;
    assign unused_lap = lap_key;
`endif

    // BCD increment with units carry into tens and 99 -> 00 wrap. The >= 9
    // tests keep the count in legal BCD even if a digit were ever corrupted.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units >= 4'd9) begin
            if (tens >= 4'd9) begin
                return 8'h00;
            end
            return {tens + 4'd1, 4'h0};
        end
        return {tens, units + 4'd1};
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        presc_d    = presc_q;
        count_d    = count_q;
        tick_d     = 1'b0;
        presc_wrap = (presc_q == PRESC_MAX);
        count_inc  = bcd_inc(count_q);
`ifdef COUNT_LAP_EN
        lap_d      = lap_q;
        lap_frz_d  = lap_frz_q;
`endif

        if (clear_key) begin
            // Clear outranks start in every state.
            state_d = S_IDLE;
            presc_d = '0;
            count_d = 8'h00;
`ifdef COUNT_LAP_EN
            lap_frz_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    count_d = 8'h00;
                    if (start_key) begin
                        state_d = S_RUN;
                    end
                end

                S_RUN: begin
                    if (presc_wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        count_d = count_inc;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end

                    // A terminal tick beats a coincident start_key; a
                    // non-terminal tick still lands before pausing. The
                    // prescaler keeps its value across a pause so the partial
                    // second is not restarted.
                    if (presc_wrap && (count_inc == target_bcd)) begin
                        state_d = S_DONE;
                    end else if (start_key) begin
                        state_d = S_PAUSE;
                    end

`ifdef COUNT_LAP_EN
                    if (lap_key) begin
                        if (lap_frz_q) begin
                            lap_frz_d = 1'b0;
                        end else begin
                            lap_frz_d = 1'b1;
                            lap_d     = count_q;
                        end
                    end
                    if (state_d == S_DONE) begin
                        lap_frz_d = 1'b0;
                    end
`endif
                end

                S_PAUSE: begin
                    if (start_key) begin
                        state_d = S_RUN;
                    end
                end

                S_DONE: begin
                    if (start_key) begin
                        state_d = S_IDLE;
                        presc_d = '0;
                        count_d = 8'h00;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

`ifdef COUNT_LAP_EN
        disp_d = lap_frz_d ? lap_d : count_d;
`else
        disp_d = count_d;
`endif
    end

    // Status outputs are registered from the next state so they line up with
    // state_q exactly: running == (state==RUN), done == (state==DONE).
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            count_q   <= 8'h00;
            disp_q    <= 8'h00;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COUNT_LAP_EN
            lap_q     <= 8'h00;
            lap_frz_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            disp_q    <= disp_d;
            tick_q    <= tick_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
`ifdef COUNT_LAP_EN
            lap_q     <= lap_d;
            lap_frz_q <= lap_frz_d;
`endif
        end
    end

    assign count_bcd = count_q;
    assign disp_bcd  = disp_q;
    assign tick      = tick_q;
    assign running   = running_q;
    assign done      = done_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_run_ctrl
//
// Directed bench for count_run_ctrl with TICK_DIV=4. Inputs change 1 ns after
// a rising edge and outputs are sampled at the same point, so every sample
// shows the state produced by the preceding edge. Expectations are hand
// computed; the lap section follows COUNT_LAP_EN.
// ---------------------------------------------------------------------------
module tb_count_run_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 3;

    logic       CLK;
    logic       Rst;
    logic       start_key;
    logic       clear_key;
    logic       lap_key;
    logic [7:0] target_bcd;
    logic [7:0] count_bcd;
    logic [7:0] disp_bcd;
    logic       tick;
    logic       running;
    logic       done;

    int n_checks;
    int n_errors;

    count_run_ctrl #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK        (CLK),
        .Rst        (Rst),
        .start_key  (start_key),
        .clear_key  (clear_key),
        .lap_key    (lap_key),
        .target_bcd (target_bcd),
        .count_bcd  (count_bcd),
        .disp_bcd   (disp_bcd),
        .tick       (tick),
        .running    (running),
        .done       (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press_start();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
    endtask

    task automatic press_clear();
        clear_key = 1'b1;
        step();
        clear_key = 1'b0;
    endtask

    task automatic press_lap();
        lap_key = 1'b1;
        step();
        lap_key = 1'b0;
    endtask

    // Step until count_bcd shows val, bounded by budget cycles.
    task automatic run_to(input string tag, input logic [7:0] val, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (count_bcd == val) break;
        end
        check(tag, count_bcd, val);
    endtask

    // Step until the next tick (bounded) and check the freshly loaded count.
    task automatic next_tick(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 16);
        check(tag, count_bcd, exp);
    endtask

    initial begin
        int         n;
        logic       saw_tick;
        logic [7:0] exp_cnt;
        logic [7:0] exp_disp;

        n_checks   = 0;
        n_errors   = 0;
        Rst        = 1'b1;
        start_key  = 1'b0;
        clear_key  = 1'b0;
        lap_key    = 1'b0;
        target_bcd = 8'hA0;

        // ---- Reset values ------------------------------------------------
        #1;
        check("rst_count",   count_bcd, 8'h00);
        check("rst_disp",    disp_bcd,  8'h00);
        check("rst_tick",    tick,      1'b0);
        check("rst_running", running,   1'b0);
        check("rst_done",    done,      1'b0);
        #2;
        Rst = 1'b0;
        step();
        check("idle_count", count_bcd, 8'h00);

        // ---- First tick latency, then async reset mid-RUN at 37 ----------
        press_start();
        check("t1_running", running, 1'b1);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 16);
        check("t1_first_tick_latency", n, TICK_DIV);
        check("t1_first_count", count_bcd, 8'h01);
        run_to("t1_reach_37", 8'h37, 300);
        #3;
        Rst = 1'b1;
        #1;
        check("t1_midrst_count",   count_bcd, 8'h00);
        check("t1_midrst_disp",    disp_bcd,  8'h00);
        check("t1_midrst_tick",    tick,      1'b0);
        check("t1_midrst_running", running,   1'b0);
        check("t1_midrst_done",    done,      1'b0);
        #1;
        Rst = 1'b0;
        saw_tick = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick) saw_tick = 1'b1;
        end
        check("t1_post_rst_no_tick", saw_tick,  1'b0);
        check("t1_post_rst_idle",    count_bcd, 8'h00);
        check("t1_post_rst_running", running,   1'b0);

        // ---- Target 12: 09 -> 10 -> 11 -> 12, then DONE ------------------
        target_bcd = 8'h12;
        press_start();
        run_to("t2_reach_09", 8'h09, 60);
        next_tick("t2_carry_10", 8'h10);
        check("t2_done_early", done, 1'b0);
        next_tick("t2_count_11", 8'h11);
        next_tick("t2_count_12", 8'h12);
        check("t2_done",    done,    1'b1);
        check("t2_running", running, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check("t2_hold_count", count_bcd, 8'h12);
        check("t2_hold_done",  done,      1'b1);
        check("t2_hold_tick",  tick,      1'b0);
        press_start();  // DONE + start behaves like clear
        check("t2_restart_count", count_bcd, 8'h00);
        check("t2_restart_done",  done,      1'b0);
        check("t2_restart_run",   running,   1'b0);

        // ---- Invalid target A0: wraps 98 -> 99 -> 00, never done ---------
        target_bcd = 8'hA0;
        press_start();
        run_to("t3_reach_98", 8'h98, 500);
        check("t3_done_98", done, 1'b0);
        next_tick("t3_count_99", 8'h99);
        next_tick("t3_wrap_00", 8'h00);
        check("t3_done_wrap",    done,    1'b0);
        check("t3_running_wrap", running, 1'b1);

        // ---- Pause two cycles into a period, hold 20, resume -------------
        next_tick("t4_count_01", 8'h01);
        step();
        press_start();
        check("t4_paused", running, 1'b0);
        saw_tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) saw_tick = 1'b1;
        end
        check("t4_pause_no_tick", saw_tick,  1'b0);
        check("t4_pause_count",   count_bcd, 8'h01);
        press_start();
        check("t4_resumed", running, 1'b1);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 16);
        check("t4_resume_latency", n, 2);
        check("t4_resume_count", count_bcd, 8'h02);

        // ---- start_key on a non-terminal tick: increment, then PAUSE -----
        for (int i = 0; i < 3; i++) step();
        press_start();
        check("t5_nonterm_count", count_bcd, 8'h03);
        check("t5_nonterm_tick",  tick,      1'b1);
        check("t5_nonterm_pause", running,   1'b0);
        for (int i = 0; i < 8; i++) step();
        check("t5_nonterm_hold", count_bcd, 8'h03);
        press_start();

        // ---- start and clear together at 45: clear wins -----------------
        run_to("t5_reach_45", 8'h45, 300);
        start_key = 1'b1;
        clear_key = 1'b1;
        step();
        start_key = 1'b0;
        clear_key = 1'b0;
        check("t5_clr_running", running,   1'b0);
        check("t5_clr_count",   count_bcd, 8'h00);
        check("t5_clr_done",    done,      1'b0);
        for (int i = 0; i < 6; i++) step();
        check("t5_clr_idle", count_bcd, 8'h00);
        check("t5_clr_tick", tick,      1'b0);

        // ---- start_key on the terminal tick: DONE, not PAUSE ------------
        target_bcd = 8'h03;
        press_start();
        next_tick("t5_term_01", 8'h01);
        next_tick("t5_term_02", 8'h02);
        for (int i = 0; i < 3; i++) step();
        press_start();
        check("t5_term_count",   count_bcd, 8'h03);
        check("t5_term_done",    done,      1'b1);
        check("t5_term_running", running,   1'b0);
        for (int i = 0; i < 3; i++) step();
        check("t5_term_still_done", done,    1'b1);
        check("t5_term_not_run",    running, 1'b0);
        press_clear();
        check("t5_term_clr_done",  done,      1'b0);
        check("t5_term_clr_count", count_bcd, 8'h00);

        // ---- Target 00: only the 99 -> 00 wrap reaches it ---------------
        target_bcd = 8'h00;
        press_start();
        run_to("t00_reach_99", 8'h99, 500);
        check("t00_done_99", done, 1'b0);
        next_tick("t00_wrap", 8'h00);
        check("t00_done", done, 1'b1);
        press_clear();

        // ---- Lap freeze at 23 while the count reaches 26 ----------------
        target_bcd = 8'hA0;
        press_start();
        run_to("t6_reach_23", 8'h23, 120);
        press_lap();
        exp_cnt = 8'h23;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) exp_cnt = exp_cnt + 8'h01;  // 23..26 has no BCD carry
`ifdef COUNT_LAP_EN
            exp_disp = 8'h23;
`else
            exp_disp = exp_cnt;
`endif
            check("t6_lap_count", count_bcd, exp_cnt);
            check("t6_lap_disp",  disp_bcd,  exp_disp);
            if (exp_cnt == 8'h26) break;
        end
        check("t6_reach_26", exp_cnt, 8'h26);
        press_lap();
        check("t6_release_disp",  disp_bcd,  8'h26);
        check("t6_release_count", count_bcd, 8'h26);
        press_clear();
        check("t6_clear_disp", disp_bcd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
